rep_seq_checker: RTL
====================

Name: rep_seq_checker

Overview:
- Synthesizable multi-channel runtime monitor for the sequence property "a ##1 b[*MIN_REP:MAX_REP] ##1 c", checked on every posedge clk.
- Each channel treats every cycle with a high as a new, independent, possibly overlapping attempt. It reports per-attempt pass and fail as one-cycle pulses and keeps saturating fail counters.
- Supports zero-length repetition (MIN_REP=0, which collapses to a ##1 c). It sits beside DUT logic as hardware equivalent of the SVA checks, for emulation and silicon debug.

Parameters:
- NCH, 1, number of independent channels.
- MIN_REP, 0, minimum consecutive b cycles; 0 <= MIN_REP <= MAX_REP.
- MAX_REP, 2, maximum consecutive b cycles; MAX_REP <= 15. MAX_REP=0 is legal.
- CNT_W, 8, width of each per-channel fail counter.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  NCH  per-channel enable.
- cnt_clr  in  1  synchronous clear of all fail counters.
- a  in  NCH  per-channel antecedent/start term.
- b  in  NCH  per-channel repeated term.
- c  in  NCH  per-channel terminating term.
- pass  out  NCH  one-cycle pulse: at least one attempt matched.
- fail  out  NCH  one-cycle pulse: at least one attempt failed.
- busy  out  NCH  channel has at least one live attempt.
- fail_cnt  out  NCH*CNT_W  saturating failed-attempt count; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset: rst_n low clears live vectors, pass, fail, busy and fail_cnt to 0 immediately. Any attempt in flight is discarded, with no pass or fail reported.
- State: per channel, live[0..MAX_REP]. live[j]=1 means the attempt started by a at cycle t-1-j has seen exactly j consecutive b cycles and is still unresolved. Each j identifies one attempt, so one bit per attempt suffices.
- Per edge, inputs sampled, for each set live[j]:
  - match = (j >= MIN_REP) and c. The attempt passes and is retired (first-match semantics). b is ignored.
  - else if (j < MAX_REP) and b: next live[j+1] = 1.
  - else: the attempt fails and is retired.
- Start: next live[0] = a and en. An a sampled at edge t is checked from edge t+1 onward. a ##1 b[*0] ##1 c equals a ##1 c.
- Outputs are registered on the same edge as the evaluation, so they are visible in the cycle after the deciding sample:
  - pass = OR of matches.
  - fail = OR of fails.
  - pass and fail may both be high in the same cycle from different attempts.
- busy = OR of next live vector (registered).
- fail_cnt:
  - Adds the number of failing attempts that edge (popcount, up to MAX_REP+1).
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr has priority: the counter loads 0 and failures on that edge are dropped.
- en low on a channel: next live cleared, no new start, pass and fail forced 0 that edge. Counters hold their value.
- Worst-case attempt latency: a to resolution is MAX_REP+1 cycles.

Test Plan:
- Defaults, NCH=1. a@0, b@1, c@2 -> pass pulse after edge 2; fail stays 0; busy high after edges 0-1, low after edge 2.
- MIN_REP=0. a@0, c@1, b low -> pass after edge 1. The zero-length match is accepted.
- Defaults. a@0, b@1, b@2, c low@1..3 -> at edge 3 live[2] has no c and cannot extend, so fail after edge 3 and fail_cnt=1.
- MIN_REP=2, MAX_REP=3. a@0, a@1, b@1, b@2, b and c low@3 -> two attempts fail on edge 3 -> single fail pulse, fail_cnt=2.
- Reset and enable. a@0, b@1, then rst_n low mid-cycle 2 -> outputs 0 immediately, no fail reported after release. With en low, a pulses -> busy, pass and fail stay 0.
- CNT_W=2, MIN_REP=0. a high and c low for 5 cycles -> fail_cnt saturates at 3. cnt_clr coincident with a failure -> fail_cnt=0.

Source files
------------

// File: rtl/rep_seq_checker_if.sv
// ---------------------------------------------------------------------------
// rep_seq_checker_if
//   Bundles the per-channel sequence terms and the checker results for
//   rep_seq_checker. Clock and reset stay outside the interface.
//
//   en       [NCH]        per-channel enable
//   cnt_clr  [1]          synchronous clear of every fail counter
//   a, b, c  [NCH]        start / repeated / terminating terms
//   pass     [NCH]        one-cycle pulse, some attempt matched
//   fail     [NCH]        one-cycle pulse, some attempt failed
//   busy     [NCH]        channel has at least one live attempt
//   fail_cnt [NCH*CNT_W]  saturating fail counters, channel i at [i*CNT_W +: CNT_W]
//
//   master: the side that drives the terms (DUT logic / bench)
//   slave : the checker
// ---------------------------------------------------------------------------
interface rep_seq_checker_if #(
    parameter int NCH   = 1,
    parameter int CNT_W = 8
);
    logic [NCH-1:0]       en;
    logic                 cnt_clr;
    logic [NCH-1:0]       a;
    logic [NCH-1:0]       b;
    logic [NCH-1:0]       c;
    logic [NCH-1:0]       pass;
    logic [NCH-1:0]       fail;
    logic [NCH-1:0]       busy;
    logic [NCH*CNT_W-1:0] fail_cnt;

    modport master (
        output en, cnt_clr, a, b, c,
        input  pass, fail, busy, fail_cnt
    );

    modport slave (
        input  en, cnt_clr, a, b, c,
        output pass, fail, busy, fail_cnt
    );
endinterface

// File: rtl/rep_seq_checker.sv
// ---------------------------------------------------------------------------
// rep_seq_checker
//   Multi-channel runtime monitor for "a ##1 b[*MIN_REP:MAX_REP] ##1 c".
//   Every cycle with a (and en) high opens a new, independent attempt; the
//   attempts of one channel may overlap. Results are registered one-cycle
//   pulses plus a saturating per-channel fail counter.
//
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset, drops all attempts silently
//   bus    rep_seq_checker_if.slave (en, cnt_clr, a, b, c -> pass, fail,
//          busy, fail_cnt)
//
//   Legal parameters: 0 <= MIN_REP <= MAX_REP <= 15, CNT_W >= 1.
// ---------------------------------------------------------------------------

// One channel of the checker.
//   en, cnt_clr, a, b, c  sampled terms
//   pass, fail, busy      registered status
//   fail_cnt              saturating count of failed attempts
module rep_seq_lane #(
    parameter int MIN_REP = 0,
    parameter int MAX_REP = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cnt_clr,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             pass,
    output logic             fail,
    output logic             busy,
    output logic [CNT_W-1:0] fail_cnt
);
    // Up to MAX_REP+1 <= 16 attempts can fail on one edge.
    localparam int NW = 5;
    localparam logic [CNT_W+NW-1:0] SAT = {{NW{1'b0}}, {CNT_W{1'b1}}};

    // live[j]: the attempt that has seen exactly j consecutive b cycles.
    // Attempts with the same j would be indistinguishable from here on,
    // so one bit per rep count is enough to track every overlap.
    logic [MAX_REP:0] live;
    logic [MAX_REP:0] nxt_live;
    logic [MAX_REP:0] match_v;
    logic [MAX_REP:0] fail_v;
    logic [NW-1:0]    nfail;
    logic [CNT_W+NW-1:0] sum;

    for (genvar j = 0; j <= MAX_REP; j++) begin : g_slot
        localparam bit CAN_END = (j >= MIN_REP);
        localparam bit CAN_EXT = (j < MAX_REP);

        // c wins over b (first match): a slot that may end and sees c
        // retires as a pass even if b is also high.
        assign match_v[j] = live[j] & c & CAN_END;
        assign fail_v[j]  = live[j] & ~(c & CAN_END) & ~(b & CAN_EXT);

        if (j == 0) begin : g_start
            assign nxt_live[0] = a;
        end else begin : g_ext
            localparam bit PREV_END = ((j - 1) >= MIN_REP);
            // Slot j-1 always has room to extend into slot j.
            assign nxt_live[j] = live[j-1] & ~(c & PREV_END) & b;
        end
    end

    always_comb begin
        nfail = '0;
        for (int j = 0; j <= MAX_REP; j++) begin
            nfail = nfail + {{(NW-1){1'b0}}, fail_v[j]};
        end
    end

    assign sum = {{NW{1'b0}}, fail_cnt} + {{CNT_W{1'b0}}, nfail};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            busy     <= 1'b0;
            fail_cnt <= '0;
        end else begin
            if (en) begin
                live <= nxt_live;
                pass <= |match_v;
                fail <= |fail_v;
                busy <= |nxt_live;
            end else begin
                // Disabled channel drops its attempts without judging them.
                live <= '0;
                pass <= 1'b0;
                fail <= 1'b0;
                busy <= 1'b0;
            end

            // Clear beats any failures on the same edge.
            if (cnt_clr) begin
                fail_cnt <= '0;
            end else if (en) begin
                fail_cnt <= (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
            end
        end
    end
endmodule

module rep_seq_checker #(
    parameter int NCH     = 1,
    parameter int MIN_REP = 0,
    parameter int MAX_REP = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rep_seq_checker_if.slave bus
);
    logic [NCH-1:0]            pass_w;
    logic [NCH-1:0]            fail_w;
    logic [NCH-1:0]            busy_w;
    logic [NCH-1:0][CNT_W-1:0] cnt_w;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        rep_seq_lane #(
            .MIN_REP (MIN_REP),
            .MAX_REP (MAX_REP),
            .CNT_W   (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (bus.en[i]),
            .cnt_clr  (bus.cnt_clr),
            .a        (bus.a[i]),
            .b        (bus.b[i]),
            .c        (bus.c[i]),
            .pass     (pass_w[i]),
            .fail     (fail_w[i]),
            .busy     (busy_w[i]),
            .fail_cnt (cnt_w[i])
        );
    end

    assign bus.pass     = pass_w;
    assign bus.fail     = fail_w;
    assign bus.busy     = busy_w;
    assign bus.fail_cnt = cnt_w;
endmodule
